// File: rtl/dx_hazard_stage.sv
// Decode-to-execute pipeline register with load-use bubble, multi-cycle mul/div hold and branch flush.
// Latency: one cycle from F/D inputs to D/X outputs. stall/flush_fd are combinational, muldiv_busy is registered.
// Backpressure: stall holds PC and F/D during a load-use bubble and while a mul/div occupies X. A taken branch overrides stall.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   fd_valid, f_d*           decoded instruction from F/D (operand numbers, values, control)
//   x_taken                  branch resolved taken in X this cycle
//   d_x*                     registered D/X contents consumed by forwarding unit and ALU
//   stall, flush_fd          hazard controls back to fetch/decode
//   muldiv_busy              mul/div FSM is in BUSY
module dx_hazard_stage #(
  parameter int DATA_W     = 16,
  parameter int MULDIV_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fd_valid,
  input  logic [3:0]        f_dop1,
  input  logic [3:0]        f_dop2,
  input  logic [DATA_W-1:0] f_dval1,
  input  logic [DATA_W-1:0] f_dval2,
  input  logic              f_dregwrite,
  input  logic              f_dmemread,
  input  logic              f_dr15write,
  input  logic              f_dbranch,
  input  logic              f_dmuldiv,
  input  logic              x_taken,
  output logic [3:0]        d_xop1,
  output logic [3:0]        d_xop2,
  output logic [DATA_W-1:0] d_xval1,
  output logic [DATA_W-1:0] d_xval2,
  output logic              d_xregwrite,
  output logic              d_xmemread,
  output logic              d_xr15write,
  output logic              d_xbranch,
  output logic              d_xmuldiv,
  output logic              d_xvalid,
  output logic              stall,
  output logic              flush_fd,
  output logic              muldiv_busy
);

  localparam int CW = $clog2(MULDIV_LAT) + 1;
  // A single-cycle mul/div never needs the BUSY state.
  localparam bit HAS_BUSY = (MULDIV_LAT > 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(MULDIV_LAT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef struct packed {
    logic              valid;
    logic [3:0]        op1;
    logic [3:0]        op2;
    logic [DATA_W-1:0] val1;
    logic [DATA_W-1:0] val2;
    logic              regwrite;
    logic              memread;
    logic              r15write;
    logic              branch;
    logic              muldiv;
  } dx_t;

  typedef enum logic {IDLE, BUSY} state_t;

  dx_t         dx_q, dx_d;
  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        lu;

  // Load in X whose destination is a source of the instruction in F/D.
  // Register 0 is hardwired, so it never creates a dependency.
  assign lu = dx_q.valid & dx_q.memread & dx_q.regwrite & (dx_q.op2 != 4'd0) &
              fd_valid & ((dx_q.op2 == f_dop1) | (dx_q.op2 == f_dop2));

  // Taken branch wins over every stall source; lu is ignored while BUSY
  // because X still holds the mul/div, not the load.
  assign stall    = ~rst & ~x_taken & ((state_q == BUSY) | lu);
  assign flush_fd = ~rst & x_taken;

  always_comb begin
    dx_d    = dx_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (x_taken) begin
      dx_d    = '0;
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == BUSY) begin
      // Last BUSY cycle is the one with cnt_q==1; stall is still high in it.
      cnt_d = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) state_d = IDLE;
    end else if (lu || !fd_valid) begin
      dx_d = '0;
    end else begin
      dx_d.valid    = 1'b1;
      dx_d.op1      = f_dop1;
      dx_d.op2      = f_dop2;
      dx_d.val1     = f_dval1;
      dx_d.val2     = f_dval2;
      dx_d.regwrite = f_dregwrite;
      dx_d.memread  = f_dmemread;
      dx_d.r15write = f_dr15write;
      dx_d.branch   = f_dbranch;
      dx_d.muldiv   = f_dmuldiv;
      if (HAS_BUSY && f_dmuldiv) begin
        state_d = BUSY;
        cnt_d   = CNT_INIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dx_q    <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      dx_q    <= dx_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign d_xvalid    = dx_q.valid;
  assign d_xop1      = dx_q.op1;
  assign d_xop2      = dx_q.op2;
  assign d_xval1     = dx_q.val1;
  assign d_xval2     = dx_q.val2;
  assign d_xregwrite = dx_q.regwrite;
  assign d_xmemread  = dx_q.memread;
  assign d_xr15write = dx_q.r15write;
  assign d_xbranch   = dx_q.branch;
  assign d_xmuldiv   = dx_q.muldiv;
  assign muldiv_busy = (state_q == BUSY);

endmodule

// File: tb/tb_dx_hazard_stage.sv
// Directed testbench for dx_hazard_stage (DATA_W=16, MULDIV_LAT=4).
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
// Instruction layout: {valid, op1, op2, val1, val2, regwrite, memread, r15write, branch, muldiv}.
module tb_dx_hazard_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        fd_valid;
  logic [3:0]  f_dop1, f_dop2;
  logic [15:0] f_dval1, f_dval2;
  logic        f_dregwrite, f_dmemread, f_dr15write, f_dbranch, f_dmuldiv;
  logic        x_taken;
  logic [3:0]  d_xop1, d_xop2;
  logic [15:0] d_xval1, d_xval2;
  logic        d_xregwrite, d_xmemread, d_xr15write, d_xbranch, d_xmuldiv, d_xvalid;
  logic        stall, flush_fd, muldiv_busy;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dx_hazard_stage #(.DATA_W(16), .MULDIV_LAT(4)) dut (
    .clk(clk), .rst(rst), .fd_valid(fd_valid),
    .f_dop1(f_dop1), .f_dop2(f_dop2), .f_dval1(f_dval1), .f_dval2(f_dval2),
    .f_dregwrite(f_dregwrite), .f_dmemread(f_dmemread), .f_dr15write(f_dr15write),
    .f_dbranch(f_dbranch), .f_dmuldiv(f_dmuldiv), .x_taken(x_taken),
    .d_xop1(d_xop1), .d_xop2(d_xop2), .d_xval1(d_xval1), .d_xval2(d_xval2),
    .d_xregwrite(d_xregwrite), .d_xmemread(d_xmemread), .d_xr15write(d_xr15write),
    .d_xbranch(d_xbranch), .d_xmuldiv(d_xmuldiv), .d_xvalid(d_xvalid),
    .stall(stall), .flush_fd(flush_fd), .muldiv_busy(muldiv_busy)
  );

  logic [45:0] dx_obs;
  assign dx_obs = {d_xvalid, d_xop1, d_xop2, d_xval1, d_xval2,
                   d_xregwrite, d_xmemread, d_xr15write, d_xbranch, d_xmuldiv};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [45:0] mk(input logic [3:0] op1, input logic [3:0] op2,
                                     input logic [15:0] v1, input logic [15:0] v2,
                                     input logic rw, input logic mr, input logic md);
    return {1'b1, op1, op2, v1, v2, rw, mr, 1'b0, 1'b0, md};
  endfunction

  task automatic apply(input logic [45:0] ins);
    {fd_valid, f_dop1, f_dop2, f_dval1, f_dval2,
     f_dregwrite, f_dmemread, f_dr15write, f_dbranch, f_dmuldiv} = ins;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  localparam logic [45:0] BUB = '0;

  logic [45:0] ld3, use1, use2, ld0, use0, mdv, nxt;

  initial begin
    ld3  = mk(4'd1, 4'd3, 16'h1111, 16'h2222, 1'b1, 1'b1, 1'b0);
    use1 = mk(4'd3, 4'd5, 16'h3333, 16'h4444, 1'b1, 1'b0, 1'b0);
    use2 = mk(4'd7, 4'd3, 16'h5555, 16'h6666, 1'b0, 1'b0, 1'b0);
    ld0  = mk(4'd1, 4'd0, 16'h7777, 16'h8888, 1'b1, 1'b1, 1'b0);
    use0 = mk(4'd0, 4'd6, 16'h9999, 16'hAAAA, 1'b1, 1'b0, 1'b0);
    mdv  = mk(4'd2, 4'd4, 16'hBBBB, 16'hCCCC, 1'b1, 1'b0, 1'b1);
    nxt  = mk(4'd8, 4'd9, 16'hDDDD, 16'hEEEE, 1'b1, 1'b0, 1'b0);

    // Reset with random inputs
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      apply({1'b1, 45'($urandom()) ^ {13'd0, 32'($urandom())}});
      x_taken = 1'($urandom_range(0, 1));
      settle();
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_flush", 64'(flush_fd), 64'd0);
      cycle();
      chk("rst_dx", 64'(dx_obs), 64'(BUB));
      chk("rst_busy", 64'(muldiv_busy), 64'd0);
    end
    x_taken = 1'b0;
    apply(BUB);
    rst = 1'b0;
    cycle();
    chk("idle_dx", 64'(dx_obs), 64'(BUB));

    // Load-use via operand 1
    apply(ld3); settle();
    chk("lu1_ld_stall", 64'(stall), 64'd0);
    cycle();
    chk("lu1_ld_dx", 64'(dx_obs), 64'(ld3));
    apply(use1); settle();
    chk("lu1_stall", 64'(stall), 64'd1);
    cycle();
    chk("lu1_bubble", 64'(dx_obs), 64'(BUB));
    settle();
    chk("lu1_stall_clr", 64'(stall), 64'd0);
    cycle();
    chk("lu1_use_dx", 64'(dx_obs), 64'(use1));

    // Load-use via operand 2
    apply(ld3); cycle();
    apply(use2); settle();
    chk("lu2_stall", 64'(stall), 64'd1);
    cycle();
    chk("lu2_bubble", 64'(dx_obs), 64'(BUB));
    settle();
    chk("lu2_stall_clr", 64'(stall), 64'd0);
    cycle();
    chk("lu2_use_dx", 64'(dx_obs), 64'(use2));

    // Load to r0 never stalls
    apply(ld0); cycle();
    chk("lu0_ld_dx", 64'(dx_obs), 64'(ld0));
    apply(use0); settle();
    chk("lu0_stall", 64'(stall), 64'd0);
    cycle();
    chk("lu0_use_dx", 64'(dx_obs), 64'(use0));

    // fd_valid=0 gives a bubble
    apply(BUB); cycle();
    chk("novalid_dx", 64'(dx_obs), 64'(BUB));

    // Mul/div holds X for 4 cycles, stalls for 3
    apply(mdv); settle();
    chk("md_pre_stall", 64'(stall), 64'd0);
    cycle();
    chk("md_dx0", 64'(dx_obs), 64'(mdv));
    chk("md_busy0", 64'(muldiv_busy), 64'd1);
    apply(nxt);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("md_stall%0d", i), 64'(stall), 64'd1);
      cycle();
      chk($sformatf("md_busy%0d", i + 1), 64'(muldiv_busy), (i < 2) ? 64'd1 : 64'd0);
      chk($sformatf("md_hold%0d", i + 1), 64'(dx_obs), 64'(mdv));
    end
    settle();
    chk("md_stall_end", 64'(stall), 64'd0);
    cycle();
    chk("md_next_dx", 64'(dx_obs), 64'(nxt));

    // Taken branch overrides load-use
    apply(ld3); cycle();
    apply(use1); x_taken = 1'b1; settle();
    chk("br_flush", 64'(flush_fd), 64'd1);
    chk("br_stall", 64'(stall), 64'd0);
    cycle();
    chk("br_dx", 64'(dx_obs), 64'(BUB));
    x_taken = 1'b0;

    // Taken branch in second BUSY cycle
    apply(mdv); cycle();
    apply(nxt); cycle();
    chk("brb_busy_pre", 64'(muldiv_busy), 64'd1);
    x_taken = 1'b1; settle();
    chk("brb_flush", 64'(flush_fd), 64'd1);
    chk("brb_stall", 64'(stall), 64'd0);
    cycle();
    chk("brb_busy", 64'(muldiv_busy), 64'd0);
    chk("brb_dx", 64'(dx_obs), 64'(BUB));
    x_taken = 1'b0; settle();
    chk("brb_stall_after", 64'(stall), 64'd0);
    cycle();
    chk("brb_next_dx", 64'(dx_obs), 64'(nxt));

    // Reset in a BUSY cycle
    apply(mdv); cycle();
    chk("mrst_busy_pre", 64'(muldiv_busy), 64'd1);
    rst = 1'b1; settle();
    chk("mrst_stall", 64'(stall), 64'd0);
    chk("mrst_flush", 64'(flush_fd), 64'd0);
    cycle();
    chk("mrst_dx", 64'(dx_obs), 64'(BUB));
    chk("mrst_busy", 64'(muldiv_busy), 64'd0);
    rst = 1'b0; apply(BUB); settle();
    chk("mrst_stall_after", 64'(stall), 64'd0);
    cycle();
    chk("mrst_busy_after", 64'(muldiv_busy), 64'd0);
    chk("mrst_dx_after", 64'(dx_obs), 64'(BUB));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
